// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decode sequencer.
// - NUM_PAIRS, PAIR_W and the derived widths.
// - State encoding of the controller FSM.
// - A helper that selects one bit pair out of a packet.
package viterbi_pkg;

  localparam int unsigned NUM_PAIRS = 8;
  localparam int unsigned PAIR_W    = 2;
  localparam int unsigned PKT_W     = PAIR_W * NUM_PAIRS;
  localparam int unsigned STEP_W    = $clog2(NUM_PAIRS);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAcs,
    StTbWait,
    StDone,
    StAbort,
    StSettle
  } state_e;

  // Pair k occupies bits [2k+1:2k] of the packet.
  function automatic logic [PAIR_W-1:0] sel_pair(input logic [PKT_W-1:0]  data,
                                                 input logic [STEP_W-1:0] idx);
    return data[idx*PAIR_W +: PAIR_W];
  endfunction

endpackage

// File: rtl/viterbi_decode_ctrl_if.sv
// Bundle between the decode sequencer and its environment
// (input buffer, branch-metric/ACS stage, traceback unit, downstream).
//   master : sequencer view - consumes enable/pkt_data/tb_done, drives the rest
//   slave  : environment view
interface viterbi_decode_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import viterbi_pkg::*;

  logic              enable;
  logic [PKT_W-1:0]  pkt_data;
  logic              tb_done;
  logic              refresh;
  logic              pm_clear;
  logic [PAIR_W-1:0] pair_out;
  logic              pair_valid;
  logic [STEP_W-1:0] step_idx;
  logic              tb_start;
  logic              out_valid;
  logic              tb_err;
  logic              busy;
  logic [CNT_W-1:0]  pkt_count;

  modport master (
    input  enable, pkt_data, tb_done,
    output refresh, pm_clear, pair_out, pair_valid, step_idx, tb_start, out_valid, tb_err,
           busy, pkt_count
  );

  modport slave (
    output enable, pkt_data, tb_done,
    input  refresh, pm_clear, pair_out, pair_valid, step_idx, tb_start, out_valid, tb_err,
           busy, pkt_count
  );

endinterface

// File: rtl/viterbi_tb_timer.sv
// Traceback wait timer: clear/enable up-counter with an expiry flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : synchronous clear to 0 (has priority over i_en)
//   i_en       : count up by one
//   o_expire   : count has reached TIMEOUT-1
module viterbi_tb_timer #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expire = (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/viterbi_decode_ctrl.sv
// Sequencer between the packet input buffer and the Viterbi core.
// Snapshots a packet, issues its bit pairs one per cycle to the ACS stage,
// starts traceback, waits for tb_done (bounded by TB_TIMEOUT) and then pulses
// refresh so the buffer advances. Sole driver of the buffer's refresh input.
//   clk, rst_n : clock, asynchronous active-low reset
//   io_bus     : master side of viterbi_decode_ctrl_if (all data/control signals)
// All outputs are registered from the next-state decode, so each pulse lines up
// with the cycle in which the FSM occupies the corresponding state.
module viterbi_decode_ctrl
  import viterbi_pkg::*;
#(
  parameter int unsigned TB_TIMEOUT = 32,
  parameter int unsigned CNT_W      = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  viterbi_decode_ctrl_if.master io_bus
);

  state_e            r_state, w_state_d;
  logic [STEP_W-1:0] r_step, w_step_d;
  logic [PKT_W-1:0]  r_snap, r_last_pkt;
  logic              w_start, w_in_wait, w_expire;

  logic              r_refresh, r_pm_clear, r_pair_valid, r_tb_start;
  logic              r_out_valid, r_tb_err, r_busy;
  logic [PAIR_W-1:0] r_pair_out;
  logic [STEP_W-1:0] r_step_idx;
  logic [CNT_W-1:0]  r_pkt_count;

  assign w_in_wait = (r_state == StTbWait);

  viterbi_tb_timer #(
    .TIMEOUT (TB_TIMEOUT)
  ) u_tb_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (!w_in_wait),
    .i_en     (w_in_wait),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_d = r_state;
    w_step_d  = r_step;
    w_start   = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Zero data means "no packet"; a repeat of the last packet is dropped.
        if (io_bus.enable && (io_bus.pkt_data != '0) && (io_bus.pkt_data != r_last_pkt)) begin
          w_state_d = StClear;
          w_start   = 1'b1;
        end
      end
      StClear: begin
        w_state_d = StAcs;
        w_step_d  = '0;
      end
      StAcs: begin
        if (r_step == STEP_W'(NUM_PAIRS - 1)) begin
          w_state_d = StTbWait;
        end else begin
          w_step_d = r_step + STEP_W'(1);
        end
      end
      StTbWait: begin
        // tb_done on the expiry cycle still counts as success.
        if (io_bus.tb_done) begin
          w_state_d = StDone;
        end else if (w_expire) begin
          w_state_d = StAbort;
        end
      end
      StDone, StAbort: w_state_d = StSettle;
      StSettle:        w_state_d = StIdle;
      default:         w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_step      <= '0;
      r_snap      <= '0;
      r_last_pkt  <= '0;
      r_refresh   <= 1'b0;
      r_pm_clear  <= 1'b0;
      r_pair_valid <= 1'b0;
      r_pair_out  <= '0;
      r_step_idx  <= '0;
      r_tb_start  <= 1'b0;
      r_out_valid <= 1'b0;
      r_tb_err    <= 1'b0;
      r_busy      <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_state <= w_state_d;
      r_step  <= w_step_d;
      if (w_start) begin
        r_snap     <= io_bus.pkt_data;
        r_last_pkt <= io_bus.pkt_data;
      end
      r_pm_clear   <= (w_state_d == StClear);
      r_pair_valid <= (w_state_d == StAcs);
      // pair_out/step_idx hold their last value outside ACS.
      if (w_state_d == StAcs) begin
        r_pair_out <= sel_pair(r_snap, w_step_d);
        r_step_idx <= w_step_d;
      end
      r_tb_start  <= (r_state == StAcs) && (w_state_d == StTbWait);
      r_out_valid <= (w_state_d == StDone);
      r_tb_err    <= (w_state_d == StAbort);
      r_refresh   <= (w_state_d == StDone) || (w_state_d == StAbort);
      r_busy      <= (w_state_d != StIdle);
      if (w_state_d == StDone) begin
        r_pkt_count <= r_pkt_count + CNT_W'(1);
      end
    end
  end

  assign io_bus.refresh    = r_refresh;
  assign io_bus.pm_clear   = r_pm_clear;
  assign io_bus.pair_out   = r_pair_out;
  assign io_bus.pair_valid = r_pair_valid;
  assign io_bus.step_idx   = r_step_idx;
  assign io_bus.tb_start   = r_tb_start;
  assign io_bus.out_valid  = r_out_valid;
  assign io_bus.tb_err     = r_tb_err;
  assign io_bus.busy       = r_busy;
  assign io_bus.pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_viterbi_decode_ctrl.sv
// Scoreboard bench for viterbi_decode_ctrl. The driver decides from the packet
// rules whether a packet starts and pushes the timed events it must produce;
// the monitor pops and compares whatever the DUT emits each cycle.
module tb_viterbi_decode_ctrl;
  import viterbi_pkg::*;

  localparam int TB_TIMEOUT = 32;
  localparam int CNT_W      = 16;

  localparam int KPmClear = 0;
  localparam int KPair    = 1;
  localparam int KTbStart = 2;
  localparam int KOut     = 3;
  localparam int KErr     = 4;
  localparam int KRefresh = 5;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  ev_t   exp_q[$];
  string kname[6] = '{"pm_clear", "pair", "tb_start", "out_valid", "tb_err", "refresh"};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  viterbi_decode_ctrl_if #(.CNT_W(CNT_W)) bus ();

  viterbi_decode_ctrl #(
    .TB_TIMEOUT (TB_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;
  int busy_lo     = 0;
  int busy_hi     = -1;
  int idle_at     = 0;
  int m_cnt       = 0;
  logic [PKT_W-1:0] m_last = '0;

  function automatic void check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic void push(input int c, input int k, input int v);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    ev_t obs[$];
    ev_t e;
    int  hold_pair;
    hold_pair = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      obs.delete();
      if (!rst_n) hold_pair = 0;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing %s: expected at cyc %0d (value %0d), not seen by cyc %0d",
                 kname[e.kind], e.cyc, e.val, cyc);
      end
      if (bus.pm_clear)   obs.push_back('{cyc, KPmClear, 0});
      if (bus.pair_valid) obs.push_back('{cyc, KPair, int'(bus.step_idx) * 4 + int'(bus.pair_out)});
      if (bus.tb_start)   obs.push_back('{cyc, KTbStart, 0});
      if (bus.out_valid)  obs.push_back('{cyc, KOut, int'(bus.pkt_count)});
      if (bus.tb_err)     obs.push_back('{cyc, KErr, int'(bus.pkt_count)});
      if (bus.refresh)    obs.push_back('{cyc, KRefresh, 0});
      foreach (obs[i]) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].kind == obs[i].kind) begin
          e = exp_q.pop_front();
          if (e.kind == KPair) hold_pair = e.val % 4;
          check(kname[e.kind], obs[i].val, e.val);
        end else begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected %s @cyc %0d: got value %0d, expected no event",
                   kname[obs[i].kind], cyc, obs[i].val);
        end
      end
      if (!bus.pair_valid) check("pair_out hold", int'(bus.pair_out), hold_pair);
      check("busy", int'(bus.busy), int'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("reset outputs",
          int'({bus.refresh, bus.pm_clear, bus.pair_out, bus.pair_valid, bus.step_idx,
                bus.tb_start, bus.out_valid, bus.tb_err, bus.busy, bus.pkt_count}), 0);
  endtask

  // One packet attempt. dly = TB_WAIT cycle on which tb_done is seen (<0: never).
  // Always returns at a falling edge with cyc == idle_at-1 or later.
  task automatic run_pkt(input logic [PKT_W-1:0] data, input logic en, input int dly,
                         input bit spur, input int hold);
    int s;
    bit done_ok;
    wait_cyc(idle_at - 1);
    bus.pkt_data = data;
    bus.enable   = en;
    bus.tb_done  = 1'b0;
    s = cyc + 1;
    if (!(en && data != '0 && data != m_last)) begin
      wait_cyc(s - 1 + hold);
      return;
    end
    m_last  = data;
    done_ok = (dly >= 0 && dly < TB_TIMEOUT);
    busy_lo = s;
    push(s, KPmClear, 0);
    for (int k = 0; k < NUM_PAIRS; k++) begin
      push(s + 1 + k, KPair, k * 4 + int'((data >> (2 * k)) & PKT_W'(3)));
    end
    push(s + NUM_PAIRS + 1, KTbStart, 0);
    if (done_ok) begin
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
      push(s + NUM_PAIRS + 2 + dly, KOut, m_cnt);
      push(s + NUM_PAIRS + 2 + dly, KRefresh, 0);
      busy_hi = s + NUM_PAIRS + 3 + dly;
    end else begin
      push(s + NUM_PAIRS + 1 + TB_TIMEOUT, KErr, m_cnt);
      push(s + NUM_PAIRS + 1 + TB_TIMEOUT, KRefresh, 0);
      busy_hi = s + NUM_PAIRS + 2 + TB_TIMEOUT;
    end
    idle_at = busy_hi + 2;
    for (int c = s; c < idle_at; c++) begin
      wait_cyc(c);
      // Scramble inputs while the snapshot is in use; they must be ignored.
      if (c <= s + NUM_PAIRS) begin
        bus.pkt_data = PKT_W'($urandom);
        bus.enable   = 1'($urandom);
      end else begin
        bus.pkt_data = data;
        bus.enable   = en;
      end
      bus.tb_done = (spur && c == s + 4) || (done_ok && c == s + NUM_PAIRS + 1 + dly);
    end
  endtask

  // Start a packet and hit reset while pair 4 is on the bus.
  task automatic run_reset_mid(input logic [PKT_W-1:0] data);
    int s;
    wait_cyc(idle_at - 1);
    bus.pkt_data = data;
    bus.enable   = 1'b1;
    bus.tb_done  = 1'b0;
    s = cyc + 1;
    busy_lo = s;
    busy_hi = s + 5;
    push(s, KPmClear, 0);
    for (int k = 0; k <= 4; k++) begin
      push(s + 1 + k, KPair, k * 4 + int'((data >> (2 * k)) & PKT_W'(3)));
    end
    wait_cyc(s + 5);
    rst_n  = 1'b0;
    m_last = '0;
    m_cnt  = 0;
    wait_cyc(s + 7);
    check_reset_outputs();
    rst_n   = 1'b1;
    idle_at = cyc + 1;
  endtask

  initial begin
    logic [PKT_W-1:0] d;
    int               r;
    bus.enable   = 1'b0;
    bus.pkt_data = '0;
    bus.tb_done  = 1'b0;
    wait_cyc(3);
    check_reset_outputs();
    rst_n   = 1'b1;
    idle_at = cyc + 1;

    run_pkt(16'h0000, 1'b1, 0, 1'b0, 20);   // no packet: stays idle
    run_pkt(16'hE4E4, 1'b1, 3, 1'b0, 1);    // pairs 0,1,2,3,0,1,2,3
    run_pkt(16'hE4E4, 1'b1, 3, 1'b0, 20);   // duplicate dropped
    run_pkt(16'h1234, 1'b1, -1, 1'b0, 1);   // traceback timeout
    run_pkt(16'hABCD, 1'b1, TB_TIMEOUT - 1, 1'b1, 1); // done on expiry, stray done in ACS
    run_pkt(16'h5A5A, 1'b1, 0, 1'b1, 1);    // minimum packet period
    run_reset_mid(16'hE4E4);
    run_pkt(16'h0F0F, 1'b0, 2, 1'b0, 10);   // enable low blocks start
    run_pkt(16'h0F0F, 1'b1, 2, 1'b0, 1);

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 7));
      if (r == 0)      d = '0;
      else if (r == 1) d = m_last;
      else             d = PKT_W'($urandom);
      run_pkt(d, 1'($urandom_range(0, 3) != 0),
              ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TB_TIMEOUT - 1)),
              1'($urandom), int'($urandom_range(1, 5)));
    end

    wait_cyc(idle_at + 3);
    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
